// File: rtl/multicycle_datapath.sv
// Multicycle MIPS datapath: one shared memory port with a req/ack handshake,
// a FETCH/DECODE/EXEC/MEM/WB sequencer, latched IR/A/B/ALUOut/MDR, and
// overflow and bus-timeout traps. Controls come from the external main decoder.
module multicycle_datapath #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] EXC_VEC     = 32'h8000_0180,
  parameter bit          TRAP_OVF    = 1'b1,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Mem2Reg,
  input  logic        ALUsrc,
  input  logic        RegDst,
  input  logic        RegWrite,
  input  logic        Jump,
  input  logic        ShiftI,
  input  logic        JumpV,
  input  logic        Link,
  input  logic        PCsrc,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        OvfEn,
  input  logic [7:0]  alucontrol,
  output logic [31:0] instr,
  output logic [31:0] PCout,
  output logic [31:0] aluout,
  output logic [31:0] RegWriteData,
  output logic        zero,
  output logic        overflow,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        inst_done,
  output logic        trap,
  output logic [31:0] epc,
  output logic [2:0]  state
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [7:0] ALU_AND  = 8'h00;
  localparam logic [7:0] ALU_OR   = 8'h01;
  localparam logic [7:0] ALU_ADD  = 8'h02;
  localparam logic [7:0] ALU_XOR  = 8'h03;
  localparam logic [7:0] ALU_SLL  = 8'h04;
  localparam logic [7:0] ALU_SRL  = 8'h05;
  localparam logic [7:0] ALU_SUB  = 8'h06;
  localparam logic [7:0] ALU_SLT  = 8'h07;
  localparam logic [7:0] ALU_NOR  = 8'h08;
  localparam logic [7:0] ALU_SRA  = 8'h09;
  localparam logic [7:0] ALU_SLTU = 8'h0A;
  localparam logic [7:0] ALU_LUI  = 8'h0B;

  localparam logic [15:0] TMO = 16'(MEM_TIMEOUT);

  logic [2:0]  state_r;
  logic [31:0] pc_r, ir_r, a_r, b_r, aluout_r, mdr_r, epc_r;
  logic        zero_r, ovf_r, inst_done_r, trap_r;
  logic [15:0] tcnt_r;
  logic [31:0] regs_r [0:31];

  logic [31:0] rd1_s, rd2_s, sext_s, alu_a_s, alu_b_s, alu_y_s;
  logic        alu_ovf_s, ovf_trap_s, ack_s, tmo_s;
  logic [31:0] pc_plus4_s, pc_plus8_s, npc_s, wd_s;
  logic [4:0]  wa_s;
  logic [15:0] tcnt_nxt_s;

  // Register $0 always reads as zero; other reads are asynchronous.
  assign rd1_s = (ir_r[25:21] == 5'd0) ? 32'd0 : regs_r[ir_r[25:21]];
  assign rd2_s = (ir_r[20:16] == 5'd0) ? 32'd0 : regs_r[ir_r[20:16]];

  assign sext_s     = {{16{ir_r[15]}}, ir_r[15:0]};
  assign alu_a_s    = ShiftI ? {27'd0, ir_r[10:6]} : a_r;
  assign alu_b_s    = ALUsrc ? sext_s : b_r;
  assign pc_plus4_s = pc_r + 32'd4;
  assign pc_plus8_s = pc_r + 32'd8;

  // Link forces $31 so jal/jalr land in the return-address register.
  assign wa_s = Link ? 5'd31 : (RegDst ? ir_r[15:11] : ir_r[20:16]);
  assign wd_s = Mem2Reg ? mdr_r : (Link ? pc_plus8_s : aluout_r);

  // Request is idle during reset and for the one cycle a trap is reported.
  assign mem_req   = ((state_r == S_FETCH) || (state_r == S_MEM)) && !trap_r && !rst;
  assign mem_we    = mem_req && (state_r == S_MEM) && MemWrite;
  assign mem_addr  = (state_r == S_MEM) ? aluout_r : pc_r;
  assign mem_wdata = b_r;

  assign ack_s      = mem_req && mem_ack;
  assign tcnt_nxt_s = tcnt_r + 16'd1;
  assign tmo_s      = (TMO != 16'd0) && mem_req && !mem_ack && (tcnt_nxt_s == TMO);
  assign ovf_trap_s = TRAP_OVF && OvfEn && alu_ovf_s;

  // ALU: result and signed overflow for add/sub.
  always_comb begin
    alu_y_s   = 32'd0;
    alu_ovf_s = 1'b0;
    case (alucontrol)
      ALU_AND:  alu_y_s = alu_a_s & alu_b_s;
      ALU_OR:   alu_y_s = alu_a_s | alu_b_s;
      ALU_XOR:  alu_y_s = alu_a_s ^ alu_b_s;
      ALU_NOR:  alu_y_s = ~(alu_a_s | alu_b_s);
      ALU_ADD: begin
        alu_y_s   = alu_a_s + alu_b_s;
        alu_ovf_s = (alu_a_s[31] == alu_b_s[31]) && (alu_y_s[31] != alu_a_s[31]);
      end
      ALU_SUB: begin
        alu_y_s   = alu_a_s - alu_b_s;
        alu_ovf_s = (alu_a_s[31] != alu_b_s[31]) && (alu_y_s[31] != alu_a_s[31]);
      end
      ALU_SLT:  alu_y_s = {31'd0, ($signed(alu_a_s) < $signed(alu_b_s))};
      ALU_SLTU: alu_y_s = {31'd0, (alu_a_s < alu_b_s)};
      ALU_SLL:  alu_y_s = alu_b_s << alu_a_s[4:0];
      ALU_SRL:  alu_y_s = alu_b_s >> alu_a_s[4:0];
      ALU_SRA:  alu_y_s = $signed(alu_b_s) >>> alu_a_s[4:0];
      ALU_LUI:  alu_y_s = {alu_b_s[15:0], 16'd0};
      default:  alu_y_s = 32'd0;
    endcase
  end

  // Next sequential/branch/jump PC; jump target keeps the upper nibble zero.
  always_comb begin
    npc_s = pc_plus4_s;
    if (Jump) begin
      if (JumpV) npc_s = a_r;
      else       npc_s = {4'd0, ir_r[25:0], 2'b00};
    end else if (PCsrc) begin
      npc_s = pc_plus4_s + {sext_s[29:0], 2'b00};
    end else begin
      npc_s = pc_plus4_s;
    end
  end

  // Register file write port; only the WB step writes, $0 is never stored.
  always_ff @(posedge clk) begin
    if ((state_r == S_WB) && RegWrite && (wa_s != 5'd0)) regs_r[wa_s] <= wd_s;
  end

  // Step sequencer with latched datapath registers, traps and wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_FETCH;
      pc_r        <= RESET_PC;
      ir_r        <= 32'd0;
      a_r         <= 32'd0;
      b_r         <= 32'd0;
      aluout_r    <= 32'd0;
      mdr_r       <= 32'd0;
      epc_r       <= 32'd0;
      zero_r      <= 1'b0;
      ovf_r       <= 1'b0;
      inst_done_r <= 1'b0;
      trap_r      <= 1'b0;
      tcnt_r      <= 16'd0;
    end else begin
      inst_done_r <= 1'b0;
      trap_r      <= 1'b0;
      case (state_r)
        S_FETCH: begin
          if (ack_s) begin
            ir_r    <= mem_rdata;
            tcnt_r  <= 16'd0;
            state_r <= S_DECODE;
          end else if (tmo_s) begin
            epc_r  <= pc_r;
            pc_r   <= EXC_VEC;
            trap_r <= 1'b1;
            tcnt_r <= 16'd0;
          end else if (mem_req) begin
            tcnt_r <= tcnt_nxt_s;
          end
        end
        S_DECODE: begin
          a_r     <= rd1_s;
          b_r     <= rd2_s;
          tcnt_r  <= 16'd0;
          state_r <= S_EXEC;
        end
        S_EXEC: begin
          aluout_r <= alu_y_s;
          zero_r   <= (alu_y_s == 32'd0);
          ovf_r    <= alu_ovf_s;
          tcnt_r   <= 16'd0;
          if (ovf_trap_s) begin
            epc_r       <= pc_r;
            pc_r        <= EXC_VEC;
            trap_r      <= 1'b1;
            inst_done_r <= 1'b1;
            state_r     <= S_FETCH;
          end else if (MemRead || MemWrite) begin
            state_r <= S_MEM;
          end else if (RegWrite) begin
            state_r <= S_WB;
          end else begin
            pc_r        <= npc_s;
            inst_done_r <= 1'b1;
            state_r     <= S_FETCH;
          end
        end
        S_MEM: begin
          if (ack_s) begin
            tcnt_r <= 16'd0;
            if (MemWrite) begin
              pc_r        <= pc_plus4_s;
              inst_done_r <= 1'b1;
              state_r     <= S_FETCH;
            end else begin
              mdr_r   <= mem_rdata;
              state_r <= S_WB;
            end
          end else if (tmo_s) begin
            epc_r       <= pc_r;
            pc_r        <= EXC_VEC;
            trap_r      <= 1'b1;
            inst_done_r <= 1'b1;
            tcnt_r      <= 16'd0;
            state_r     <= S_FETCH;
          end else if (mem_req) begin
            tcnt_r <= tcnt_nxt_s;
          end
        end
        S_WB: begin
          pc_r        <= npc_s;
          inst_done_r <= 1'b1;
          tcnt_r      <= 16'd0;
          state_r     <= S_FETCH;
        end
        default: begin
          state_r <= S_FETCH;
          tcnt_r  <= 16'd0;
        end
      endcase
    end
  end

  assign instr        = ir_r;
  assign PCout        = pc_r;
  assign aluout       = aluout_r;
  assign RegWriteData = wd_s;
  assign zero         = zero_r;
  assign overflow     = ovf_r;
  assign inst_done    = inst_done_r;
  assign trap         = trap_r;
  assign epc          = epc_r;
  assign state        = state_r;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench: the bench plays both decoder and memory. u0 traps on
// overflow with a 4-cycle bus timeout; u1 ignores overflow and has no timeout.
module tb_multicycle_datapath;

  localparam logic [11:0] M2R = 12'h001, SRC = 12'h002, DST = 12'h004, RW  = 12'h008;
  localparam logic [11:0] JMP = 12'h010, SHI = 12'h020, JV  = 12'h040, LNK = 12'h080;
  localparam logic [11:0] PCS = 12'h100, MR  = 12'h200, MW  = 12'h400, OVE = 12'h800;
  localparam logic [7:0]  A_AND = 8'h00, A_OR = 8'h01, A_ADD = 8'h02, A_SLL = 8'h04;
  localparam logic [7:0]  A_SRL = 8'h05, A_SUB = 8'h06, A_SLT = 8'h07;
  localparam logic [31:0] EXC = 32'h8000_0180;

  logic clk = 1'b0;
  logic rst;
  logic Mem2Reg, ALUsrc, RegDst, RegWrite, Jump, ShiftI, JumpV, Link, PCsrc;
  logic MemRead, MemWrite, OvfEn;
  logic [7:0]  alucontrol;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic [31:0] instr, PCout, aluout, RegWriteData, mem_addr, mem_wdata, epc;
  logic        zero, overflow, mem_req, mem_we, inst_done, trap;
  logic [2:0]  state;
  logic [31:0] u1_instr, u1_PCout, u1_aluout, u1_wd, u1_mem_addr, u1_mem_wdata, u1_epc;
  logic        u1_zero, u1_overflow, u1_mem_req, u1_mem_we, u1_inst_done, u1_trap;
  logic [2:0]  u1_state;

  always #5 clk = ~clk;

  multicycle_datapath #(.TRAP_OVF(1'b1), .MEM_TIMEOUT(4)) u0 (
    .clk(clk), .rst(rst), .Mem2Reg(Mem2Reg), .ALUsrc(ALUsrc), .RegDst(RegDst),
    .RegWrite(RegWrite), .Jump(Jump), .ShiftI(ShiftI), .JumpV(JumpV), .Link(Link),
    .PCsrc(PCsrc), .MemRead(MemRead), .MemWrite(MemWrite), .OvfEn(OvfEn),
    .alucontrol(alucontrol), .instr(instr), .PCout(PCout), .aluout(aluout),
    .RegWriteData(RegWriteData), .zero(zero), .overflow(overflow), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .inst_done(inst_done), .trap(trap), .epc(epc), .state(state));

  multicycle_datapath #(.TRAP_OVF(1'b0), .MEM_TIMEOUT(0)) u1 (
    .clk(clk), .rst(rst), .Mem2Reg(Mem2Reg), .ALUsrc(ALUsrc), .RegDst(RegDst),
    .RegWrite(RegWrite), .Jump(Jump), .ShiftI(ShiftI), .JumpV(JumpV), .Link(Link),
    .PCsrc(PCsrc), .MemRead(MemRead), .MemWrite(MemWrite), .OvfEn(OvfEn),
    .alucontrol(alucontrol), .instr(u1_instr), .PCout(u1_PCout), .aluout(u1_aluout),
    .RegWriteData(u1_wd), .zero(u1_zero), .overflow(u1_overflow), .mem_req(u1_mem_req),
    .mem_we(u1_mem_we), .mem_addr(u1_mem_addr), .mem_wdata(u1_mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .inst_done(u1_inst_done), .trap(u1_trap),
    .epc(u1_epc), .state(u1_state));

  typedef struct {
    logic [31:0] iw;
    logic [11:0] ctl;
    logic [7:0]  alu;
    logic [31:0] exp_alu;
    logic        exp_zero;
    logic        exp_wr;
    logic [31:0] exp_wd;
    logic [31:0] exp_pc;
    int          exp_cyc;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  // Results of the last run_instr call.
  int          r_cyc, r_mem_cyc;
  logic [31:0] r_wd, r_u1_wd, r_addr, r_wdata;
  logic        r_wd_seen, r_u1_seen, r_trap, r_addr_stable, r_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_ctl(input logic [11:0] c, input logic [7:0] op);
    Mem2Reg = c[0];  ALUsrc = c[1];  RegDst = c[2];   RegWrite = c[3];
    Jump    = c[4];  ShiftI = c[5];  JumpV  = c[6];   Link     = c[7];
    PCsrc   = c[8];  MemRead = c[9]; MemWrite = c[10]; OvfEn   = c[11];
    alucontrol = op;
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'd0;
    set_ctl(12'h000, 8'h00);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // Runs one instruction from its first FETCH cycle until inst_done is seen.
  // Fetch is zero-wait; the MEM step is acked after 'waits' idle cycles.
  task automatic run_instr(input logic [31:0] iw, input logic [11:0] c, input logic [7:0] op,
                           input int waits, input logic [31:0] mrd);
    int w = 0;
    r_cyc = -1; r_mem_cyc = 0; r_wd = 32'd0; r_u1_wd = 32'd0; r_wd_seen = 1'b0;
    r_u1_seen = 1'b0; r_trap = 1'b0; r_addr_stable = 1'b1; r_we = 1'b0;
    r_addr = 32'd0; r_wdata = 32'd0;
    mem_ack = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (state == 3'd4) begin r_wd = RegWriteData; r_wd_seen = 1'b1; end
      if (u1_state == 3'd4) begin r_u1_wd = u1_wd; r_u1_seen = 1'b1; end
      if (i > 0 && trap) r_trap = 1'b1;
      if (i > 0 && inst_done) begin r_cyc = i; break; end
      set_ctl(c, op);
      mem_ack = 1'b0; mem_rdata = 32'd0;
      if (mem_req && state == 3'd0) begin
        mem_ack = 1'b1; mem_rdata = iw;
      end else if (mem_req && state == 3'd3) begin
        if (r_mem_cyc == 0) begin r_addr = mem_addr; r_we = mem_we; r_wdata = mem_wdata; end
        else if (mem_addr !== r_addr || mem_we !== r_we) r_addr_stable = 1'b0;
        r_mem_cyc++;
        if (w == waits) begin mem_ack = 1'b1; mem_rdata = mrd; end
        else w++;
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
  endtask

  vec_t tab [11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //            iw            ctl               alu    exp_alu       z     wr    wd            pc           cyc
    tab[0]  = '{32'h20010005, SRC|RW,          A_ADD, 32'd5,        1'b0, 1'b1, 32'd5,        32'h4,       4};
    tab[1]  = '{32'h00211020, DST|RW,          A_ADD, 32'd10,       1'b0, 1'b1, 32'd10,       32'h8,       4};
    tab[2]  = '{32'h10000002, PCS,             A_SUB, 32'd0,        1'b1, 1'b0, 32'd0,        32'h14,      3};
    tab[3]  = '{32'h0C000040, JMP|LNK|RW,      A_ADD, 32'd0,        1'b1, 1'b1, 32'h1C,       32'h100,     4};
    tab[4]  = '{32'h00412022, DST|RW,          A_SUB, 32'd5,        1'b0, 1'b1, 32'd5,        32'h104,     4};
    tab[5]  = '{32'h000128C0, DST|RW|SHI,      A_SLL, 32'd40,       1'b0, 1'b1, 32'd40,       32'h108,     4};
    tab[6]  = '{32'h3406FFFF, SRC|RW,          A_OR,  32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h10C,     4};
    tab[7]  = '{32'h00C1382A, DST|RW,          A_SLT, 32'd1,        1'b0, 1'b1, 32'd1,        32'h110,     4};
    tab[8]  = '{32'h03E00008, JMP|JV,          A_ADD, 32'h1C,       1'b0, 1'b0, 32'd0,        32'h1C,      3};
    tab[9]  = '{32'h03E54020, DST|RW,          A_ADD, 32'h44,       1'b0, 1'b1, 32'h44,       32'h20,      4};
    tab[10] = '{32'h00000000, 12'h000,         A_AND, 32'd0,        1'b1, 1'b0, 32'd0,        32'h24,      3};

    // Reset state
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'd0;
    set_ctl(12'h000, 8'h00);
    @(negedge clk); @(negedge clk);
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_pc", PCout, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_done_trap", {30'd0, inst_done, trap}, 32'd0);
    chk("rst_ir_alu", instr | aluout | epc, 32'd0);
    rst = 1'b0;
    #1;
    chk("req_after_rst", {31'd0, mem_req}, 32'd1);
    chk("addr_after_rst", mem_addr, 32'd0);

    // Table of zero-wait ALU / branch / jump instructions
    for (int k = 0; k < 11; k++) begin
      run_instr(tab[k].iw, tab[k].ctl, tab[k].alu, 0, 32'd0);
      chk($sformatf("cyc[%0d]", k), 32'(r_cyc), 32'(tab[k].exp_cyc));
      chk($sformatf("alu[%0d]", k), aluout, tab[k].exp_alu);
      chk($sformatf("zero[%0d]", k), {31'd0, zero}, {31'd0, tab[k].exp_zero});
      chk($sformatf("pc[%0d]", k), PCout, tab[k].exp_pc);
      chk($sformatf("wb[%0d]", k), {31'd0, r_wd_seen}, {31'd0, tab[k].exp_wr});
      if (tab[k].exp_wr) chk($sformatf("wd[%0d]", k), r_wd, tab[k].exp_wd);
    end

    // lw $3,0($0) with three wait cycles
    run_instr(32'h8C030000, MR|M2R|RW|SRC, A_ADD, 3, 32'hDEADBEEF);
    chk("lw_cyc", 32'(r_cyc), 32'd8);
    chk("lw_req_cycles", 32'(r_mem_cyc), 32'd4);
    chk("lw_stable", {31'd0, r_addr_stable}, 32'd1);
    chk("lw_addr_we", {r_addr[30:0], r_we}, 32'd0);
    chk("lw_wd", r_wd, 32'hDEADBEEF);
    chk("lw_pc", PCout, 32'h28);

    // sw $1,8($0) zero-wait
    run_instr(32'hAC010008, MW|SRC, A_ADD, 0, 32'd0);
    chk("sw_cyc", 32'(r_cyc), 32'd4);
    chk("sw_we", {31'd0, r_we}, 32'd1);
    chk("sw_addr", r_addr, 32'd8);
    chk("sw_wdata", r_wdata, 32'd5);
    chk("sw_pc", PCout, 32'h2C);

    // srl $9,$6,1 -> 7FFFFFFF ; addi $10,$0,7
    run_instr(32'h00064842, DST|RW|SHI, A_SRL, 0, 32'd0);
    chk("srl_alu", aluout, 32'h7FFFFFFF);
    run_instr(32'h200A0007, SRC|RW, A_ADD, 0, 32'd0);
    chk("addi10_pc", PCout, 32'h34);

    // addi $10,$9,1 with OvfEn: u0 traps, u1 writes 80000000
    run_instr(32'h212A0001, SRC|RW|OVE, A_ADD, 0, 32'd0);
    chk("ovf_cyc", 32'(r_cyc), 32'd3);
    chk("ovf_trap", {31'd0, r_trap}, 32'd1);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_epc", epc, 32'h34);
    chk("ovf_pc", PCout, EXC);
    chk("ovf_no_wb", {31'd0, r_wd_seen}, 32'd0);
    chk("noovf_wd", r_u1_wd, 32'h80000000);
    chk("noovf_wb", {31'd0, r_u1_seen}, 32'd1);

    // add $11,$10,$0 at the vector: $10 must still hold 7
    run_instr(32'h01405820, DST|RW, A_ADD, 0, 32'd0);
    chk("dest_unchanged", aluout, 32'd7);
    chk("vec_pc", PCout, EXC + 32'd4);

    // Fetch timeout: ack never arrives
    do_reset();
    repeat (3) @(negedge clk);
    chk("tmo_pre_trap", {30'd0, trap, mem_req}, 32'd1);
    @(negedge clk);
    chk("tmo_trap", {31'd0, trap}, 32'd1);
    chk("tmo_req_low", {31'd0, mem_req}, 32'd0);
    chk("tmo_pc", PCout, EXC);
    @(negedge clk);
    chk("tmo_refetch", {mem_addr[31:1], mem_req}, {EXC[31:1], 1'b1});

    // Ack on the fourth waiting cycle beats the timeout
    do_reset();
    repeat (3) @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late_ack_no_trap", {31'd0, trap}, 32'd0);
    chk("late_ack_state", {29'd0, state}, 32'd1);
    chk("late_ack_ir", instr, 32'h12345678);

    // Reset in the middle of a store's MEM step
    do_reset();
    set_ctl(MW|SRC, A_ADD);
    mem_ack = 1'b1; mem_rdata = 32'hAC010008;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("sw_in_mem", {28'd0, state, mem_we}, {28'd0, 3'd3, 1'b1});
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_req", {30'd0, mem_req, mem_we}, 32'd0);
    chk("midrst_pc", PCout, 32'd0);
    chk("midrst_state", {29'd0, state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_resume", {mem_addr[31:1], mem_req}, 32'd1);
    run_instr(32'h00000000, 12'h000, A_AND, 0, 32'd0);
    chk("resume_cyc", 32'(r_cyc), 32'd3);
    chk("resume_pc", PCout, 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
